// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, result-select encodings and helpers for the ALU datapath.
package alu_pkg;
    localparam int ALU_N = 16;
    localparam logic [3:0] SEL_ADD   = 4'b0001;
    localparam logic [3:0] SEL_MULT  = 4'b0010;
    localparam logic [3:0] SEL_DIV   = 4'b0100;
    localparam logic [3:0] SEL_LOGIC = 4'b1000;
    // Output FIFO entry layout: {carry, zero, data}
    typedef struct packed {
        logic             carry;
        logic             zero;
        logic [ALU_N-1:0] data;
    } entry_t;
    function automatic logic is_onehot(input logic [3:0] s);
        return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: small registered FIFO; head reads as zero when empty, no fall-through or bypass.
module result_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         not_full,
    output logic         not_empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    always_comb begin
        not_full  = cnt_q < CAP;
        not_empty = cnt_q != '0;
        do_push   = push & not_full;
        do_pop    = pop & not_empty;
        mem_d     = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout  = not_empty ? mem_q[rd_q] : '0;
    end
    // Storage needs no reset: the head is masked by the count.
    always_ff @(posedge clk) mem_q <= mem_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: selects the functional-unit result, updates the accumulator and
// queues {carry, zero, data} for a valid/ready consumer.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   res_s,
    input  logic [N-1:0] r0,
    input  logic [N-1:0] r1,
    input  logic [N-1:0] r2,
    input  logic [N-1:0] r3,
    input  logic         carry_in,
    input  logic         acc_we,
    input  logic         acc_clr,
    output logic [N-1:0] acc_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero,
    output logic         out_carry,
    output logic         sel_err,
    output logic [7:0]   txn_cnt
);
    logic [N-1:0] sel, acc_q, acc_d;
    logic [N+1:0] head;
    logic         accept, push, sel_err_q, sel_err_d;
    logic [7:0]   txn_cnt_q, txn_cnt_d;
    always_comb begin
        sel = ({N{res_s[3]}} & r3) | ({N{res_s[2]}} & r2) | ({N{res_s[1]}} & r1) | ({N{res_s[0]}} & r0);
        accept    = in_valid & in_ready;
        push      = accept & is_onehot(res_s);
        sel_err_d = sel_err_q | (accept & ~is_onehot(res_s));
        txn_cnt_d = txn_cnt_q + 8'(push);
        acc_d     = acc_clr ? '0 : (push & acc_we) ? sel : acc_q;
    end
    result_fifo #(.W(N + 2), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (out_ready),
        .din       ({carry_in & res_s[0], sel == '0, sel}),
        .not_full  (in_ready),
        .not_empty (out_valid),
        .dout      (head)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            sel_err_q <= 1'b0;
            txn_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            sel_err_q <= sel_err_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end
    assign acc_val   = acc_q;
    assign sel_err   = sel_err_q;
    assign txn_cnt   = txn_cnt_q;
    assign out_data  = head[N-1:0];
    assign out_zero  = head[N];
    assign out_carry = head[N+1];
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed-vector bench for alu_result_stage with DEPTH=2.
module tb_alu_result_stage;
    logic        clk = 0, rst_n = 0;
    logic        in_valid, in_ready, carry_in, acc_we, acc_clr;
    logic [3:0]  res_s;
    logic [15:0] r0, r1, r2, r3, acc_val, out_data;
    logic        out_valid, out_ready, out_zero, out_carry, sel_err;
    logic [7:0]  txn_cnt;
    int checks = 0, errors = 0;

    alu_result_stage #(.N(16), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .res_s(res_s),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .carry_in(carry_in), .acc_we(acc_we),
        .acc_clr(acc_clr), .acc_val(acc_val), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_carry(out_carry), .sel_err(sel_err),
        .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; res_s = 4'b0001; r0 = 0; r1 = 0; r2 = 0; r3 = 0;
        carry_in = 0; acc_we = 0; acc_clr = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({out_valid, out_zero, out_carry, sel_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, out_zero, out_carry, sel_err}); end
        checks++; if (out_data !== 16'h0000 || acc_val !== 16'h0000 || txn_cnt !== 8'd0) begin errors++; $display("FAIL reset_data data=%h acc=%h txn=%0d exp=0", out_data, acc_val, txn_cnt); end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_add();
        in_valid = 1; res_s = 4'b0001; r0 = 16'h0000; carry_in = 1; acc_we = 1;
        tick();
        idle();
        checks++; if ({out_valid, out_zero, out_carry} !== 3'b111) begin errors++; $display("FAIL add_flags got=%b exp=111", {out_valid, out_zero, out_carry}); end
        checks++; if (out_data !== 16'h0000 || acc_val !== 16'h0000) begin errors++; $display("FAIL add_data data=%h acc=%h exp=0000", out_data, acc_val); end
        checks++; if (txn_cnt !== 8'd1) begin errors++; $display("FAIL add_txn got=%0d exp=1", txn_cnt); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin errors++; $display("FAIL add_drain valid=%b data=%h exp=0/0000", out_valid, out_data); end
    endtask

    task automatic test_full();
        in_valid = 1; res_s = 4'b0010; r1 = 16'h0006; carry_in = 1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_one_ready got=%b exp=1", in_ready); end
        res_s = 4'b0100; r2 = 16'h0003;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        res_s = 4'b0001; r0 = 16'h0077;
        tick();
        checks++; if (txn_cnt !== 8'd3 || in_ready !== 1'b0) begin errors++; $display("FAIL full_held txn=%0d ready=%b exp=3/0", txn_cnt, in_ready); end
        checks++; if (out_data !== 16'h0006 || out_carry !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL full_head0 data=%h c=%b z=%b exp=0006/0/0", out_data, out_carry, out_zero); end
        idle();
        out_ready = 1;
        tick();
        checks++; if (out_data !== 16'h0003 || out_carry !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_head1 data=%h c=%b v=%b exp=0003/0/1", out_data, out_carry, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_freed got=%b exp=1", in_ready); end
        tick();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || txn_cnt !== 8'd3) begin errors++; $display("FAIL full_drain v=%b data=%h txn=%0d exp=0/0000/3", out_valid, out_data, txn_cnt); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; res_s = 4'b0001; r0 = 16'h0100;
        tick();
        for (int i = 0; i < 10; i++) begin
            r0 = 16'h0101 + 16'(i);
            out_ready = 1;
            checks++; if (out_data !== 16'h0100 + 16'(i) || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_%0d data=%h v=%b r=%b exp=%h/1/1", i, out_data, out_valid, in_ready, 16'h0100 + 16'(i)); end
            tick();
        end
        idle();
        checks++; if (out_data !== 16'h010A || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_last data=%h v=%b r=%b exp=010a/1/1", out_data, out_valid, in_ready); end
        checks++; if (txn_cnt !== 8'd14) begin errors++; $display("FAIL b2b_txn got=%0d exp=14", txn_cnt); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_bad_select();
        in_valid = 1; res_s = 4'b1000; r3 = 16'h1234; acc_we = 1;
        tick();
        checks++; if (acc_val !== 16'h1234 || out_data !== 16'h1234 || txn_cnt !== 8'd15) begin errors++; $display("FAIL bad_pre acc=%h data=%h txn=%0d exp=1234/1234/15", acc_val, out_data, txn_cnt); end
        res_s = 4'b0011; r0 = 16'h5555; r1 = 16'h5555; out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (sel_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bad_0011 err=%b v=%b exp=1/0", sel_err, out_valid); end
        checks++; if (txn_cnt !== 8'd15 || acc_val !== 16'h1234) begin errors++; $display("FAIL bad_0011_state txn=%0d acc=%h exp=15/1234", txn_cnt, acc_val); end
        res_s = 4'b0000;
        tick();
        checks++; if (sel_err !== 1'b1 || out_valid !== 1'b0 || txn_cnt !== 8'd15 || acc_val !== 16'h1234) begin errors++; $display("FAIL bad_0000 err=%b v=%b txn=%0d acc=%h exp=1/0/15/1234", sel_err, out_valid, txn_cnt, acc_val); end
        res_s = 4'b0001; r0 = 16'h0042; acc_we = 0;
        tick();
        idle();
        checks++; if (sel_err !== 1'b1 || out_data !== 16'h0042 || txn_cnt !== 8'd16 || acc_val !== 16'h1234) begin errors++; $display("FAIL bad_sticky err=%b data=%h txn=%0d acc=%h exp=1/0042/16/1234", sel_err, out_data, txn_cnt, acc_val); end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_acc_priority();
        in_valid = 1; res_s = 4'b1000; r3 = 16'hBEEF; acc_we = 1; acc_clr = 1;
        tick();
        checks++; if (acc_val !== 16'h0000 || out_data !== 16'hBEEF || out_zero !== 1'b0 || txn_cnt !== 8'd17) begin errors++; $display("FAIL prio acc=%h data=%h z=%b txn=%0d exp=0000/beef/0/17", acc_val, out_data, out_zero, txn_cnt); end
        acc_clr = 0; r3 = 16'h0011; out_ready = 1;
        tick();
        checks++; if (acc_val !== 16'h0011 || out_data !== 16'h0011 || txn_cnt !== 8'd18) begin errors++; $display("FAIL prio_load acc=%h data=%h txn=%0d exp=0011/0011/18", acc_val, out_data, txn_cnt); end
        in_valid = 0; acc_we = 0; acc_clr = 1;
        tick();
        acc_clr = 0;
        checks++; if (acc_val !== 16'h0000 || out_valid !== 1'b0) begin errors++; $display("FAIL prio_clr acc=%h v=%b exp=0000/0", acc_val, out_valid); end
        in_valid = 1; res_s = 4'b0001; out_ready = 1;
        for (int i = 0; i < 256; i++) begin
            r0 = 16'(i);
            tick();
        end
        idle();
        checks++; if (txn_cnt !== 8'd18) begin errors++; $display("FAIL wrap_txn got=%0d exp=18", txn_cnt); end
        checks++; if (out_data !== 16'h00FF || acc_val !== 16'h0000) begin errors++; $display("FAIL wrap_head data=%h acc=%h exp=00ff/0000", out_data, acc_val); end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1; res_s = 4'b0001; r0 = 16'h00A5; carry_in = 1; acc_we = 1;
        tick();
        r0 = 16'h005A;
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h00A5) begin errors++; $display("FAIL mid_pre v=%b r=%b data=%h exp=1/0/00a5", out_valid, in_ready, out_data); end
        #2;
        rst_n = 0;
        #1;
        checks++; if ({in_ready, out_valid, out_zero, out_carry, sel_err} !== 5'b10000) begin errors++; $display("FAIL mid_flags got=%b exp=10000", {in_ready, out_valid, out_zero, out_carry, sel_err}); end
        checks++; if (out_data !== 16'h0000 || acc_val !== 16'h0000 || txn_cnt !== 8'd0) begin errors++; $display("FAIL mid_data data=%h acc=%h txn=%0d exp=0", out_data, acc_val, txn_cnt); end
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_stale v=%b data=%h r=%b exp=0/0000/1", out_valid, out_data, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_full();
        test_back_to_back();
        test_bad_select();
        test_acc_priority();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Output end of the ALU datapath: the counterpart to the input register stage. It takes the four functional-unit results, selects one with a one-hot select, optionally writes it into the accumulator, and buffers it with flags in a small FIFO for a valid/ready downstream consumer. `acc_val` from this block is the accumulator operand fed back into the input register stage's B mux.

## Interface
Parameters:
- `N`, 16: data width.
- `DEPTH`, 2: output FIFO entries; power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: result presented.
- `in_ready`, output, 1: stage can accept; `in_ready = (count < DEPTH)`.
- `res_s`, input, 4: one-hot result select. Bit 0 selects `r0` (add), bit 1 `r1` (mult), bit 2 `r2` (div), bit 3 `r3` (logic/shift).
- `r0`, `r1`, `r2`, `r3`, input, N each: functional-unit results.
- `carry_in`, input, 1: adder carry-out. Meaningful only when `res_s` = 4'b0001.
- `acc_we`, input, 1: write the selected result to the accumulator on accept.
- `acc_clr`, input, 1: synchronous accumulator clear.
- `acc_val`, output, N: accumulator register.
- `out_valid`, output, 1: FIFO head valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_data`, output, N: head data; 0 when empty.
- `out_zero`, output, 1: head data == 0; 0 when empty.
- `out_carry`, output, 1: head carry flag; 0 when empty.
- `sel_err`, output, 1: sticky flag; set when a non-one-hot select is accepted.
- `txn_cnt`, output, 8: count of enqueued transactions; wraps at 256.

## Operation
Accept and select:
- Accept occurs when `in_valid & in_ready`.
- Selected value is `({N{res_s[3]}}&r3) | ({N{res_s[2]}}&r2) | ({N{res_s[1]}}&r1) | ({N{res_s[0]}}&r0)`.
- Carry flag is `carry_in & res_s[0]`.
- Select not exactly one-hot (including 4'b0000) at accept:
  - transaction is consumed, with `in_ready` honoured;
  - nothing is enqueued;
  - accumulator and `txn_cnt` are unchanged;
  - `sel_err` becomes 1 and stays 1 until reset.

Valid accept:
- Push {data, data==0, carry} at the write pointer.
- Increment `txn_cnt`, mod 256.
- If `acc_we`, load the accumulator with the data.

Accumulator:
- `acc_clr` takes priority over the load. When both are active, `acc_val` becomes 0.
- `acc_clr` acts whether or not an accept happens.

Pop:
- `out_valid & out_ready` advances the read pointer.

FIFO pointers and count:
- Pointers are `log2(DEPTH)` bits and wrap mod DEPTH.
- Count is `log2(DEPTH)+1` bits.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Full: `in_ready` = 0, so no push can happen. A pop in the full cycle frees a slot that is visible the next cycle; there is no same-cycle bypass.
- Empty: `out_valid` = 0 and a pop is impossible. There is no fall-through of input to output in the same cycle.

## Timing
- Reset values:
  - `acc_val` = 0, `out_valid` = 0, `out_data` = 0, `out_zero` = 0, `out_carry` = 0;
  - `sel_err` = 0, `txn_cnt` = 0, count = 0, pointers = 0;
  - `in_ready` = 1.
- Reset asserted mid-operation discards all FIFO contents immediately, asynchronously.
- Latency:
  - A result accepted at edge k is `out_valid` from after edge k, with `out_data`/flags stable until popped.
  - `acc_val` updates after edge k.
- `in_ready` and `out_valid` are derived only from registered count; there is no combinational path from `in_valid` or `out_ready`.
- Flags are computed at push and stored; they are not recomputed at the head.
- Throughput is one transaction per cycle while neither full nor stalled.

## Structure
- Shared package `alu_pkg`:
  - `ALU_N` = 16;
  - select constants `SEL_ADD`=4'b0001, `SEL_MULT`=4'b0010, `SEL_DIV`=4'b0100, `SEL_LOGIC`=4'b1000;
  - FIFO entry layout `{carry, zero, data}`, N+2 bits.
- One sub-module, `result_fifo`, parameterised by width and DEPTH. It holds storage, pointers, count, full/empty and the head outputs.
- Select logic, one-hot check, accumulator and `txn_cnt` stay in the top.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with 2 entries queued. Required: all outputs at reset values, `in_ready`=1, and no stale entry after release.
- **Single add:** `res_s`=0001, `r0`=16'h0000, `carry_in`=1, `acc_we`=1, `out_ready`=0. Required next cycle: `out_valid`=1, `out_data`=0, `out_zero`=1, `out_carry`=1, `acc_val`=0, `txn_cnt`=1.
- **Full back-pressure:** push mult 0x0006 then div 0x0003 with `out_ready`=0. Required: `in_ready`=0 after the 2nd accept and a third `in_valid` is held off. Raise `out_ready` and pops must return 0x0006 then 0x0003 with `out_carry`=0.
- **Simultaneous push/pop:** one entry queued, push with `out_ready`=1 for 10 cycles using distinct values. Required: count stays 1, outputs appear in order one cycle late, and the pointers wrap correctly.
- **Bad select:** `res_s`=0011, then 0000, with `in_valid`=1. Required: `sel_err`=1 (sticky), nothing enqueued, `txn_cnt` and `acc_val` unchanged.
- **Accumulator priority:** `acc_we`=1 and `acc_clr`=1 with `r3`=0xBEEF. Required: `acc_val`=0 while the FIFO still receives 0xBEEF. Then 256 valid pushes; `txn_cnt` must wrap back to its start value.
